// File: rtl/pmp_csr_requester_if.sv
// Bundle of the execute-side handshake, the writeback result and the PMP CSR request bus.
// master = requester (drives the CSR request and the result), slave = execute stage plus responder.
interface pmp_csr_requester_if #(
    parameter int REG_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_funct3;
    logic [11:0]          in_csr_addr;
    logic [4:0]           in_rs1_idx;
    logic [REG_WIDTH-1:0] in_rs1_val;
    logic [4:0]           in_rd_idx;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_rd_idx;
    logic [REG_WIDTH-1:0] out_rd_wdata;
    logic                 out_wr_en;
    logic                 out_exc;
    logic [1:0]           out_exc_cause;

    logic                 csr_req_en;
    logic [1:0]           csr_req_op;
    logic [2:0]           csr_funct3;
    logic [4:0]           csr_imm;
    logic [REG_WIDTH-1:0] rs1_val;
    logic [11:0]          csr_req_addr;
    logic                 csr_rrsp;
    logic [31:0]          csr_req_rdata;
    logic                 csr_req_rvalid;
    logic                 csr_act_rsp;

    modport master (
        input  in_valid, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd_idx, flush,
        input  out_ready, csr_req_rdata, csr_req_rvalid, csr_act_rsp,
        output in_ready, out_valid, out_rd_idx, out_rd_wdata, out_wr_en, out_exc, out_exc_cause,
        output csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp
    );

    modport slave (
        output in_valid, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd_idx, flush,
        output out_ready, csr_req_rdata, csr_req_rvalid, csr_act_rsp,
        input  in_ready, out_valid, out_rd_idx, out_rd_wdata, out_wr_en, out_exc, out_exc_cause,
        input  csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp
    );
endinterface

// File: rtl/pmp_csr_requester.sv
// Zicsr initiator for the PMP CSR port: decodes one instruction, issues a single-cycle
// CSR request, captures the old value and returns a writeback or exception result.
module pmp_csr_requester #(
    parameter int PMP_CHANNEL_NUM = 32,
    parameter int REG_WIDTH       = 32
) (
    input  logic                clk,
    input  logic                rst,
    pmp_csr_requester_if.master bus
);
    localparam logic [11:0] CFG_BASE  = 12'h3A0;
    localparam logic [11:0] CFG_END   = 12'(32'h3A0 + PMP_CHANNEL_NUM / 4);
    localparam logic [11:0] ADDR_BASE = 12'h3B0;
    localparam logic [11:0] ADDR_END  = 12'(32'h3B0 + PMP_CHANNEL_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2:0]           funct3_q;
    logic [11:0]          addr_q;
    logic [4:0]           rs1_idx_q;
    logic [REG_WIDTH-1:0] rs1_val_q;
    logic [4:0]           rd_idx_q;
    logic [1:0]           op_q;
    logic [REG_WIDTH-1:0] result_q;
    logic                 exc_q;
    logic [1:0]           cause_q;

    logic       accept;
    logic       req_en;
    logic       resp_st;
    logic       funct3_bad;
    logic       addr_bad;
    logic [1:0] op_d;

    assign accept     = bus.in_valid & bus.in_ready;
    assign funct3_bad = (bus.in_funct3[1:0] == 2'b00);
    assign addr_bad   = !(((bus.in_csr_addr >= CFG_BASE)  && (bus.in_csr_addr < CFG_END)) ||
                          ((bus.in_csr_addr >= ADDR_BASE) && (bus.in_csr_addr < ADDR_END)));

    // CSRRW(I) skips the read when rd is x0; CSRRS/C(I) skip the write when rs1/uimm is 0.
    always_comb begin
        op_d = 2'b00;
        case (bus.in_funct3[1:0])
            2'b01:        op_d = {bus.in_rd_idx != 5'd0, 1'b1};
            2'b10, 2'b11: op_d = {1'b1, bus.in_rs1_idx != 5'd0};
            default:      op_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= 3'd0;
            addr_q    <= 12'd0;
            rs1_idx_q <= 5'd0;
            rs1_val_q <= '0;
            rd_idx_q  <= 5'd0;
            op_q      <= 2'b00;
            result_q  <= '0;
            exc_q     <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q  <= bus.in_funct3;
                        addr_q    <= bus.in_csr_addr;
                        rs1_idx_q <= bus.in_rs1_idx;
                        rs1_val_q <= bus.in_rs1_val;
                        rd_idx_q  <= bus.in_rd_idx;
                        op_q      <= op_d;
                        result_q  <= '0;
                        exc_q     <= funct3_bad | addr_bad;
                        cause_q   <= funct3_bad ? 2'b01 : (addr_bad ? 2'b10 : 2'b00);
                        state_q   <= (funct3_bad | addr_bad) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        // Responder read data is combinational and only valid in this cycle.
                        result_q <= op_q[1] ? REG_WIDTH'(bus.csr_req_rdata) : '0;
                        if (bus.csr_act_rsp) begin
                            exc_q   <= 1'b1;
                            cause_q <= 2'b11;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (bus.flush || bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_en  = (state_q == ISSUE) & ~bus.flush;
    assign resp_st = (state_q == RESP);

    assign bus.in_ready      = (state_q == IDLE) & ~bus.flush;
    assign bus.csr_req_en    = req_en;
    assign bus.csr_req_op    = req_en ? op_q : 2'b00;
    assign bus.csr_funct3    = funct3_q;
    assign bus.csr_imm       = rs1_idx_q;
    assign bus.rs1_val       = rs1_val_q;
    assign bus.csr_req_addr  = addr_q;

    assign bus.out_valid     = resp_st & ~bus.flush;
    // A flushed result still releases the responder's held read-valid.
    assign bus.csr_rrsp      = resp_st & (bus.out_ready | bus.flush);
    assign bus.out_rd_idx    = rd_idx_q;
    assign bus.out_rd_wdata  = result_q;
    assign bus.out_wr_en     = bus.out_valid & ~exc_q & (rd_idx_q != 5'd0) & op_q[1];
    assign bus.out_exc       = bus.out_valid & exc_q;
    assign bus.out_exc_cause = bus.out_valid ? cause_q : 2'b00;

    assert property (@(posedge clk) disable iff (rst) req_en |-> bus.csr_req_rvalid);
    assert property (@(posedge clk) disable iff (rst) !(req_en && bus.csr_rrsp));
endmodule

// File: doc/pmp_csr_requester.md
Name: pmp_csr_requester

Overview:
- Initiator side of the PMP CSR access port: accepts one decoded Zicsr instruction from execute, drives a single-cycle CSR request into the PMP unit, captures the old CSR value, and hands a writeback/exception result back to the pipeline.
- Sits between the execute stage and the PMP CSR responder.
- Owns RISC-V read/write suppression rules, PMP address-range decode and clearing of the responder's held read-valid.

Parameters:
- PMP_CHANNEL_NUM, 32, number of PMP entries. Must be a multiple of 4. Legal cfg CSRs are 0x3A0..0x3A0+PMP_CHANNEL_NUM/4-1; legal addr CSRs are 0x3B0..0x3B0+PMP_CHANNEL_NUM-1.
- REG_WIDTH, 32, register and data width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  instruction offered
- in_ready  output  1  block can accept
- in_funct3  input  3  Zicsr funct3
- in_csr_addr  input  12  CSR address
- in_rs1_idx  input  5  rs1 field / uimm
- in_rs1_val  input  REG_WIDTH  rs1 value
- in_rd_idx  input  5  destination register
- flush  input  1  pipeline kill
- out_valid  output  1  result available
- out_ready  input  1  result consumed
- out_rd_idx  output  5  destination register
- out_rd_wdata  output  REG_WIDTH  old CSR value
- out_wr_en  output  1  write rd
- out_exc  output  1  illegal-instruction exception
- out_exc_cause  output  2  01 bad funct3, 10 address out of range, 11 privilege
- csr_req_en  output  1  request strobe
- csr_req_op  output  2  [1] = read, [0] = write
- csr_funct3  output  3  forwarded funct3
- csr_imm  output  5  uimm (= latched rs1_idx)
- rs1_val  output  REG_WIDTH  latched rs1 value
- csr_req_addr  output  12  latched CSR address
- csr_rrsp  output  1  response consumed; clears responder read-valid
- csr_req_rdata  input  32  responder read data (combinational, valid only while csr_req_en & op[1])
- csr_req_rvalid  input  1  responder valid
- csr_act_rsp  input  1  responder privilege reject, same cycle as csr_req_en

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset, including mid-operation: state IDLE, all capture registers 0, every output 0 except in_ready = 1.
- IDLE:
  - in_ready = ~flush.
  - On in_valid & in_ready, latch all in_* fields.
  - funct3 000 or 100: go to RESP with exc = 1, cause 01.
  - Address outside the legal ranges: go to RESP with exc = 1, cause 10.
  - Otherwise go to ISSUE.
  - No CSR request is issued on either exception path.
- ISSUE (exactly one cycle):
  - csr_req_en = 1, and csr_funct3/imm/rs1_val/addr are driven from the latches.
  - funct3[1:0] = 01 (CSRRW/CSRRWI): op[1] = (rd_idx != 0), op[0] = 1.
  - funct3[1:0] = 10 or 11: op[1] = 1, op[0] = (rs1_idx != 0).
  - In the same cycle, capture csr_req_rdata into the result register when op[1]; otherwise the result is 0.
  - In the same cycle, capture csr_act_rsp. If it is 1: exc = 1, cause 11.
  - csr_req_rvalid low in ISSUE is a protocol violation. It is flagged by an assertion only; the behaviour is otherwise unchanged.
  - Go to RESP.
- RESP:
  - out_valid = 1.
  - out_wr_en = ~exc & (rd_idx != 0) & op[1].
  - out_rd_wdata = captured value.
  - csr_rrsp = out_valid & out_ready, for exactly one cycle. On that handshake go to IDLE.
  - Outputs are held stable while out_ready = 0.
- Flush:
  - Flush in ISSUE forces csr_req_en = 0 (no CSR side effect) and returns to IDLE.
  - Flush in RESP drops the result (out_valid = 0 that cycle), pulses csr_rrsp = 1 and returns to IDLE.
  - Flush in IDLE blocks acceptance.
- Throughput: at most one instruction per 3 cycles. in_ready = 0 outside IDLE.
- Result latency is 2 cycles from acceptance for a legal access, and 1 cycle for an exception.
- csr_rrsp is never asserted in the same cycle as csr_req_en.

Test Plan:
- CSRRS, rs1_idx = 0, rd = 5, addr 0x3B3, responder holds 0x1234_5678, machine mode -> one csr_req_en cycle with op = 10; out_rd_wdata = 0x1234_5678, out_wr_en = 1; csr_rrsp pulses on the out_ready handshake.
- CSRRW, rd = 0, addr 0x3A0, rs1 = 0x0000_0F0F -> op = 01, out_wr_en = 0; a subsequent CSRRS read of 0x3A0 returns 0x0000_0F0F.
- CSRRWI at 0x3A8 (PMP_CHANNEL_NUM = 32) -> no csr_req_en; out_exc = 1, cause 10, 1 cycle after acceptance. funct3 = 100 -> cause 01.
- User-mode access, csr_act_rsp = 1 -> out_exc = 1, cause 11, out_wr_en = 0.
- out_ready held low for 4 cycles in RESP -> outputs stable, in_ready = 0, csr_rrsp = 0 until the handshake. flush asserted in ISSUE -> csr_req_en stays 0 and in_ready = 1 the next cycle.
- rst asserted in ISSUE -> outputs 0 immediately (asynchronously); after release a new CSRRC completes normally.
